bp_be_pair_dispatch: RTL and testbench

- Sits directly downstream of the dual-slot BE issue queue.
- Each cycle it inspects the two head entries and their pre-decoded issue packets, then decides to dispatch both, one, or none.
- It acknowledges the queue with yumi strobes and registers the selected pair into a valid/ready dispatch register feeding the scheduler.
- It serializes CSR and fence instructions: no further dispatch occurs until the serializing instruction retires.

---
 rtl/bp_be_pkg.sv | 50 +++++
 rtl/bp_be_pair_hazard.sv | 40 ++++
 rtl/bp_be_pair_dispatch.sv | 154 +++++++++++++++
 tb/tb_bp_be_pair_dispatch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared BE types and constants for the pair-dispatch slice: configuration enum,
// FE queue entry and issue packet layouts, instruction field positions.
package bp_be_pkg;

    typedef enum logic {e_bp_default_cfg} bp_params_e;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;
    localparam int rd_offset_gp   = 7;
    localparam int rd_width_gp    = 5;

    localparam logic [6:0] opcode_branch_gp = 7'b1100011;
    localparam logic [6:0] opcode_jal_gp    = 7'b1101111;
    localparam logic [6:0] opcode_jalr_gp   = 7'b1100111;

    typedef enum logic {e_run, e_drain} bp_be_pair_dispatch_state_e;

    typedef struct packed {
        logic [vaddr_width_gp-1:0] pc;
        logic [instr_width_gp-1:0] instr;
    } bp_fe_queue_s;

    typedef struct packed {
        logic [7:0] fu_op;
        logic       csr_v;
        logic       fence_v;
        logic       mem_v;
        logic       long_v;
        logic       irs1_v;
        logic       irs2_v;
        logic       frs1_v;
        logic       frs2_v;
        logic       frs3_v;
    } bp_be_issue_pkt_s;

    function automatic int bp_fe_queue_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_queue_s);
            default:          return $bits(bp_fe_queue_s);
        endcase
    endfunction

    function automatic int bp_issue_pkt_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_be_issue_pkt_s);
            default:          return $bits(bp_be_issue_pkt_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_be_pair_hazard.sv
// Combinational co-issue check: decides whether the head+1 entry may dispatch
// alongside the head entry in the same cycle.
module bp_be_pair_hazard
    import bp_be_pkg::*;
(
    input  logic [rd_width_gp-1:0] i_rd1,
    input  logic [6:0]             i_opcode1,
    input  logic                   i_serial1,
    input  logic                   i_mem1,
    input  logic                   i_long1,
    input  logic                   i_serial2,
    input  logic                   i_mem2,
    input  logic                   i_long2,
    input  logic [rd_width_gp-1:0] i_src1,
    input  logic [rd_width_gp-1:0] i_src2,
    input  logic [rd_width_gp-1:0] i_src3,
    input  logic                   i_src1_v,
    input  logic                   i_src2_v,
    input  logic                   i_src3_v,
    output logic                   o_pair_ok
);

    logic w_raw;
    logic w_ctrl1;

    // rd write-enable is not decoded, so any rd match blocks the pair
    assign w_raw = (i_src1_v & (i_src1 == i_rd1))
                 | (i_src2_v & (i_src2 == i_rd1))
                 | (i_src3_v & (i_src3 == i_rd1));

    assign w_ctrl1 = (i_opcode1 == opcode_branch_gp)
                   | (i_opcode1 == opcode_jal_gp)
                   | (i_opcode1 == opcode_jalr_gp);

    assign o_pair_ok = ~(i_serial1 | i_serial2
                       | (i_mem1 & i_mem2)
                       | (i_long1 & i_long2)
                       | w_raw | w_ctrl1);

endmodule

// File: rtl/bp_be_pair_dispatch.sv
// Dual-slot BE dispatch: acks the issue queue and registers up to two entries per cycle,
// holding off after CSR/fence until retire. BP_BE_PAIR_DISPATCH_STATS_EN adds event counters.
module bp_be_pair_dispatch
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
    , parameter int stat_width_p = 32
`endif
    , localparam int fe_queue_width_lp  = bp_fe_queue_width(bp_params_p)
    , localparam int issue_pkt_width_lp = bp_issue_pkt_width(bp_params_p)
)(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [fe_queue_width_lp-1:0]  fe_queue1_i,
    input  logic [fe_queue_width_lp-1:0]  fe_queue2_i,
    input  logic                          fe_queue_v1_i,
    input  logic                          fe_queue_v2_i,
    output logic                          fe_queue_yumi1_o,
    output logic                          fe_queue_yumi2_o,
    input  logic [issue_pkt_width_lp-1:0] issue_pkt1_i,
    input  logic [issue_pkt_width_lp-1:0] issue_pkt2_i,
    input  logic                          flush_i,
    input  logic                          serial_done_i,
    output logic                          dispatch_v1_o,
    output logic                          dispatch_v2_o,
    input  logic                          dispatch_ready_i,
    output logic [fe_queue_width_lp-1:0]  dispatch_fe1_o,
    output logic [fe_queue_width_lp-1:0]  dispatch_fe2_o,
    output logic [issue_pkt_width_lp-1:0] dispatch_pkt1_o,
    output logic [issue_pkt_width_lp-1:0] dispatch_pkt2_o,
    output logic                          stall_o
`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
    , output logic [stat_width_p-1:0]     stat_dual_o
    , output logic [stat_width_p-1:0]     stat_single_o
    , output logic [stat_width_p-1:0]     stat_stall_o
`endif
);

    bp_fe_queue_s     w_fe1, w_fe2, r_fe1, r_fe2;
    bp_be_issue_pkt_s w_pkt1, w_pkt2, r_pkt1, r_pkt2;
    bp_be_pair_dispatch_state_e r_state, w_state_nxt;

    logic r_v1, r_v2;
    logic w_free, w_can1, w_can2, w_pair_ok, w_serial1, w_stall;

    assign w_fe1  = fe_queue1_i;
    assign w_fe2  = fe_queue2_i;
    assign w_pkt1 = issue_pkt1_i;
    assign w_pkt2 = issue_pkt2_i;

    assign w_serial1 = w_pkt1.csr_v | w_pkt1.fence_v;
    assign w_free    = ~r_v1 | dispatch_ready_i;

    // reset_n_i gates the strobes so the queue sees no yumi while reset is held
    assign w_can1  = reset_n_i & w_free & fe_queue_v1_i & (r_state == e_run) & ~flush_i;
    assign w_can2  = w_can1 & fe_queue_v2_i & w_pair_ok;
    assign w_stall = reset_n_i & fe_queue_v1_i & ~w_can1 & ~flush_i;

    bp_be_pair_hazard u_hazard (
        .i_rd1     (w_fe1.instr[rd_offset_gp +: rd_width_gp]),
        .i_opcode1 (w_fe1.instr[6:0]),
        .i_serial1 (w_serial1),
        .i_mem1    (w_pkt1.mem_v),
        .i_long1   (w_pkt1.long_v),
        .i_serial2 (w_pkt2.csr_v | w_pkt2.fence_v),
        .i_mem2    (w_pkt2.mem_v),
        .i_long2   (w_pkt2.long_v),
        .i_src1    (w_fe2.instr[19:15]),
        .i_src2    (w_fe2.instr[24:20]),
        .i_src3    (w_fe2.instr[31:27]),
        .i_src1_v  (w_pkt2.irs1_v | w_pkt2.frs1_v),
        .i_src2_v  (w_pkt2.irs2_v | w_pkt2.frs2_v),
        .i_src3_v  (w_pkt2.frs3_v),
        .o_pair_ok (w_pair_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = e_run;
        end else begin
            case (r_state)
                e_run:   if (w_can1 & w_serial1) w_state_nxt = e_drain;
                e_drain: if (serial_done_i)      w_state_nxt = e_run;
                default: w_state_nxt = e_run;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_fe1  <= '0;
            r_fe2  <= '0;
            r_pkt1 <= '0;
            r_pkt2 <= '0;
        end else if (flush_i) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (w_free) begin
            r_v1 <= w_can1;
            r_v2 <= w_can2;
            if (w_can1) begin
                r_fe1  <= w_fe1;
                r_fe2  <= w_fe2;
                r_pkt1 <= w_pkt1;
                r_pkt2 <= w_pkt2;
            end
        end
    end

    assign fe_queue_yumi1_o = w_can1;
    assign fe_queue_yumi2_o = w_can2;
    assign dispatch_v1_o    = r_v1;
    assign dispatch_v2_o    = r_v2;
    assign dispatch_fe1_o   = r_fe1;
    assign dispatch_fe2_o   = r_fe2;
    assign dispatch_pkt1_o  = r_pkt1;
    assign dispatch_pkt2_o  = r_pkt2;
    assign stall_o          = w_stall;

`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
    localparam logic [stat_width_p-1:0] stat_one_lp = 1;

    logic [stat_width_p-1:0] r_dual, r_single, r_stall;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_dual   <= '0;
            r_single <= '0;
            r_stall  <= '0;
        end else begin
            if (w_can2)           r_dual   <= r_dual + stat_one_lp;
            if (w_can1 & ~w_can2) r_single <= r_single + stat_one_lp;
            if (w_stall)          r_stall  <= r_stall + stat_one_lp;
        end
    end

    assign stat_dual_o   = r_dual;
    assign stat_single_o = r_single;
    assign stat_stall_o  = r_stall;
`endif

endmodule

// File: tb/tb_bp_be_pair_dispatch.sv
// Bench for bp_be_pair_dispatch: directed scenarios then random traffic against a
// queue-level reference model. Also checks counters when BP_BE_PAIR_DISPATCH_STATS_EN is set.
module tb_bp_be_pair_dispatch;
    import bp_be_pkg::*;

    localparam int FEW = $bits(bp_fe_queue_s);
    localparam int PW  = $bits(bp_be_issue_pkt_s);

    logic clk, rst_n;
    logic v1, v2, ready, flush, sdone;
    bp_fe_queue_s     fe1, fe2;
    bp_be_issue_pkt_s pkt1, pkt2;
    logic yumi1, yumi2, dv1, dv2, stall;
    logic [FEW-1:0] dfe1, dfe2;
    logic [PW-1:0]  dpkt1, dpkt2;
`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
    logic [31:0] stat_dual, stat_single, stat_stall;
`endif

    bp_be_pair_dispatch dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .fe_queue1_i      (fe1),
        .fe_queue2_i      (fe2),
        .fe_queue_v1_i    (v1),
        .fe_queue_v2_i    (v2),
        .fe_queue_yumi1_o (yumi1),
        .fe_queue_yumi2_o (yumi2),
        .issue_pkt1_i     (pkt1),
        .issue_pkt2_i     (pkt2),
        .flush_i          (flush),
        .serial_done_i    (sdone),
        .dispatch_v1_o    (dv1),
        .dispatch_v2_o    (dv2),
        .dispatch_ready_i (ready),
        .dispatch_fe1_o   (dfe1),
        .dispatch_fe2_o   (dfe2),
        .dispatch_pkt1_o  (dpkt1),
        .dispatch_pkt2_o  (dpkt2),
        .stall_o          (stall)
`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
        , .stat_dual_o    (stat_dual)
        , .stat_single_o  (stat_single)
        , .stat_stall_o   (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit               m_drain;
    bit               m_v1, m_v2;
    bp_fe_queue_s     m_fe1, m_fe2;
    bp_be_issue_pkt_s m_pkt1, m_pkt2;
    int unsigned      m_dual, m_single, m_stall;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(logic [4:0] rd, logic [4:0] rs1);
        return {12'd1, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] i_csrrw(logic [4:0] rd, logic [4:0] rs1);
        return {12'h300, rs1, 3'b001, rd, 7'b1110011};
    endfunction

    function automatic bp_fe_queue_s mk_fe(logic [31:0] instr);
        bp_fe_queue_s f;
        f.pc    = {7'($urandom()), $urandom()};
        f.instr = instr;
        return f;
    endfunction

    function automatic bp_be_issue_pkt_s mk_pkt(bit rs1_v, bit rs2_v, bit csr);
        bp_be_issue_pkt_s p;
        p        = '0;
        p.fu_op  = 8'($urandom());
        p.irs1_v = rs1_v;
        p.irs2_v = rs2_v;
        p.csr_v  = csr;
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: return i_add(rd, rs1, rs2);
            1: return i_addi(rd, rs1);
            2: return i_csrrw(rd, rs1);
            3: return {20'h0, rd, 7'b1101111};
            4: return {7'b0, rs2, rs1, 3'b000, rd, 7'b1100011};
            default: return {12'd4, rs1, 3'b010, rd, 7'b0000011};
        endcase
    endfunction

    function automatic bp_be_issue_pkt_s rand_pkt();
        bp_be_issue_pkt_s p;
        p.fu_op   = 8'($urandom());
        p.csr_v   = ($urandom_range(0, 11) == 0);
        p.fence_v = ($urandom_range(0, 19) == 0);
        p.mem_v   = ($urandom_range(0, 2) == 0);
        p.long_v  = ($urandom_range(0, 3) == 0);
        p.irs1_v  = 1'($urandom());
        p.irs2_v  = 1'($urandom());
        p.frs1_v  = ($urandom_range(0, 5) == 0);
        p.frs2_v  = ($urandom_range(0, 5) == 0);
        p.frs3_v  = ($urandom_range(0, 5) == 0);
        return p;
    endfunction

    // Co-issue rules written as a list of reasons to refuse, sources gathered in a queue.
    function automatic bit pair_allowed(bp_fe_queue_s f1, bp_be_issue_pkt_s p1,
                                        bp_fe_queue_s f2, bp_be_issue_pkt_s p2);
        logic [4:0] srcs[$];
        logic [6:0] op;
        if (p1.csr_v || p1.fence_v || p2.csr_v || p2.fence_v) return 1'b0;
        if (p1.mem_v && p2.mem_v)   return 1'b0;
        if (p1.long_v && p2.long_v) return 1'b0;
        op = f1.instr[6:0];
        if (op == 7'h63 || op == 7'h6f || op == 7'h67) return 1'b0;
        if (p2.irs1_v || p2.frs1_v) srcs.push_back(f2.instr[19:15]);
        if (p2.irs2_v || p2.frs2_v) srcs.push_back(f2.instr[24:20]);
        if (p2.frs3_v)              srcs.push_back(f2.instr[31:27]);
        foreach (srcs[i]) if (srcs[i] == f1.instr[11:7]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_drain = 0; m_v1 = 0; m_v2 = 0;
        m_fe1 = '0; m_fe2 = '0; m_pkt1 = '0; m_pkt2 = '0;
        m_dual = 0; m_single = 0; m_stall = 0;
    endtask

    task automatic peek(string tag, bit ey1, bit ey2, bit est);
        #1;
        chk({tag, "_yumi1"}, yumi1, ey1);
        chk({tag, "_yumi2"}, yumi2, ey2);
        chk({tag, "_stall"}, stall, est);
    endtask

    // One clock: check strobes before the edge, advance model, check the register after it.
    task automatic step();
        bit free, y1, y2, st;
        #1;
        free = !m_v1 || ready;
        y1   = free && v1 && !m_drain && !flush;
        y2   = y1 && v2 && pair_allowed(fe1, pkt1, fe2, pkt2);
        st   = v1 && !y1 && !flush;
        chk("yumi1", yumi1, y1);
        chk("yumi2", yumi2, y2);
        chk("stall", stall, st);
        @(posedge clk);
        if (flush) begin
            m_v1 = 0; m_v2 = 0;
        end else if (free) begin
            m_v1 = y1; m_v2 = y2;
            if (y1) begin
                m_fe1 = fe1; m_fe2 = fe2; m_pkt1 = pkt1; m_pkt2 = pkt2;
            end
        end
        if (flush)                                  m_drain = 0;
        else if (y1 && (pkt1.csr_v || pkt1.fence_v)) m_drain = 1;
        else if (m_drain && sdone)                  m_drain = 0;
        if (y2) m_dual++;
        else if (y1) m_single++;
        if (st) m_stall++;
        #1;
        chk("disp_v1", dv1, m_v1);
        chk("disp_v2", dv2, m_v2);
        chk("disp_fe1", dfe1, m_fe1);
        chk("disp_fe2", dfe2, m_fe2);
        chk("disp_pkt1", dpkt1, m_pkt1);
        chk("disp_pkt2", dpkt2, m_pkt2);
    endtask

    task automatic rand_inputs();
        v1    = ($urandom_range(0, 4) != 0);
        v2    = v1 ? 1'($urandom()) : ($urandom_range(0, 7) == 0);
        fe1   = mk_fe(rand_instr());
        fe2   = mk_fe(rand_instr());
        pkt1  = rand_pkt();
        pkt2  = rand_pkt();
        ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 19) == 0);
        sdone = ($urandom_range(0, 3) == 0);
    endtask

    task automatic check_stats();
`ifdef BP_BE_PAIR_DISPATCH_STATS_EN
        chk("stat_dual", stat_dual, m_dual);
        chk("stat_single", stat_single, m_single);
        chk("stat_stall", stat_stall, m_stall);
`endif
    endtask

    initial begin
        bp_fe_queue_s saved_fe1;

        // reset held with a valid head: nothing may be acknowledged
        rst_n = 0; v1 = 1; v2 = 1; ready = 1; flush = 0; sdone = 0;
        fe1 = mk_fe(i_add(5'd1, 5'd5, 5'd6)); fe2 = mk_fe(i_add(5'd2, 5'd3, 5'd4));
        pkt1 = mk_pkt(1, 1, 0); pkt2 = mk_pkt(1, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_yumi1", yumi1, 0);
        chk("rst_yumi2", yumi2, 0);
        chk("rst_stall", stall, 0);
        chk("rst_v1", dv1, 0);
        chk("rst_v2", dv2, 0);
        chk("rst_fe1", dfe1, 0);
        chk("rst_pkt2", dpkt2, 0);
        check_stats();
        rst_n = 1;

        // independent ADD pair
        peek("indep", 1, 1, 0);
        step();
        chk("indep_v2", dv2, 1);
        chk("indep_pkt2", dpkt2, pkt2);

        // RAW on x5: only the head goes
        fe1 = mk_fe(i_addi(5'd5, 5'd1)); pkt1 = mk_pkt(1, 0, 0);
        fe2 = mk_fe(i_add(5'd7, 5'd5, 5'd6)); pkt2 = mk_pkt(1, 1, 0);
        peek("raw", 1, 0, 0);
        step();
        chk("raw_v2", dv2, 0);
        fe1 = fe2; pkt1 = pkt2;
        fe2 = mk_fe(i_add(5'd8, 5'd1, 5'd2)); pkt2 = mk_pkt(1, 1, 0);
        peek("raw_next", 1, 1, 0);
        step();

        // CSRRW serializes until retire
        fe1 = mk_fe(i_csrrw(5'd9, 5'd1)); pkt1 = mk_pkt(1, 0, 1);
        fe2 = mk_fe(i_add(5'd10, 5'd3, 5'd4)); pkt2 = mk_pkt(1, 1, 0);
        peek("csr", 1, 0, 0);
        step();
        fe1 = fe2; pkt1 = pkt2;
        fe2 = mk_fe(i_add(5'd11, 5'd3, 5'd4)); pkt2 = mk_pkt(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            peek("drain", 0, 0, 1);
            step();
        end
        sdone = 1;
        peek("drain_done", 0, 0, 1);
        step();
        sdone = 0;
        peek("resume", 1, 1, 0);
        step();

        // back-pressure: register holds for 4 cycles, then takes the new pair
        fe1 = mk_fe(i_add(5'd12, 5'd1, 5'd2)); fe2 = mk_fe(i_add(5'd13, 5'd3, 5'd4));
        pkt1 = mk_pkt(1, 1, 0); pkt2 = mk_pkt(1, 1, 0);
        step();
        saved_fe1 = fe1;
        ready = 0;
        fe1 = mk_fe(i_add(5'd14, 5'd1, 5'd2)); fe2 = mk_fe(i_add(5'd15, 5'd3, 5'd4));
        for (int i = 0; i < 4; i++) begin
            peek("full", 0, 0, 1);
            step();
            chk("full_hold_fe1", dfe1, saved_fe1);
        end
        ready = 1;
        peek("full_release", 1, 1, 0);
        step();
        chk("full_new_fe1", dfe1, fe1);

        // flush with valid register and no ready
        ready = 0; flush = 1;
        peek("flush", 0, 0, 0);
        step();
        chk("flush_v1", dv1, 0);
        flush = 0;
        peek("post_flush", 1, 1, 0);
        step();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end
        check_stats();

        // asynchronous reset mid-cycle
        v1 = 1; v2 = 1; ready = 1; flush = 0;
        fe1 = mk_fe(i_add(5'd1, 5'd2, 5'd3)); fe2 = mk_fe(i_add(5'd4, 5'd5, 5'd6));
        pkt1 = mk_pkt(1, 1, 0); pkt2 = mk_pkt(1, 1, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("arst_yumi1", yumi1, 0);
        chk("arst_stall", stall, 0);
        chk("arst_v1", dv1, 0);
        chk("arst_v2", dv2, 0);
        chk("arst_fe2", dfe2, 0);
        chk("arst_pkt1", dpkt1, 0);
        check_stats();
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            step();
        end
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
